// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the writeback stage and its wait timer.
package wb_stage_pkg;

    localparam int TIMEOUT_DEFAULT = 15;
    localparam int WAIT_CNT_W      = 8;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } wb_state_e;

    typedef enum logic [1:0] {
        OP_ALU   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2,
        OP_BAD   = 2'd3
    } op_class_e;

    // An instruction flagged as both load and store is malformed and gets OP_BAD.
    function automatic op_class_e classify_op(input logic is_load, input logic is_store);
        op_class_e result;
        case ({is_load, is_store})
            2'b00:   result = OP_ALU;
            2'b10:   result = OP_LOAD;
            2'b01:   result = OP_STORE;
            default: result = OP_BAD;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Upstream, data-memory and register-file signals of the writeback stage.
interface wb_stage_if #(
    parameter int raw = 4
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic             is_load_i;
    logic             is_store_i;
    logic [7:0]       alu_result_i;
    logic [7:0]       mem_addr_i;
    logic [7:0]       store_data_i;
    logic [raw-1:0]   rt_addr_i;
    logic             func_i;

    logic             mem_req_o;
    logic             mem_we_o;
    logic [7:0]       mem_addr_o;
    logic [7:0]       mem_wdata_o;
    logic             mem_ack_i;
    logic [7:0]       mem_rdata_i;

    logic             wen_o;
    logic [7:0]       write_data_o;
    logic [raw-1:0]   rt_addr_o;
    logic             func_o;
    logic             err_o;

    // The stage itself.
    modport slave (
        input  in_valid_i, is_load_i, is_store_i, alu_result_i, mem_addr_i,
               store_data_i, rt_addr_i, func_i, mem_ack_i, mem_rdata_i,
        output in_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
               wen_o, write_data_o, rt_addr_o, func_o, err_o
    );

    // The surrounding pipeline and memory.
    modport master (
        output in_valid_i, is_load_i, is_store_i, alu_result_i, mem_addr_i,
               store_data_i, rt_addr_i, func_i, mem_ack_i, mem_rdata_i,
        input  in_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
               wen_o, write_data_o, rt_addr_o, func_o, err_o
    );

endinterface

// File: rtl/wb_stage_wait_timer.sv
// Counts memory-wait cycles without an acknowledge and flags when LIMIT is reached.
module wb_stage_wait_timer
    import wb_stage_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam logic [WAIT_CNT_W-1:0] LIMIT_CNT = WAIT_CNT_W'(LIMIT);

    logic [WAIT_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= count + WAIT_CNT_W'(1);
        end
    end

    assign expired = (count == LIMIT_CNT);

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results directly and runs loads/stores against
// data memory with a bounded wait, reporting malformed ops and timeouts on err_o.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int raw     = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    wb_stage_if.slave  bus
);

    wb_state_e      state;
    wb_state_e      state_next;
    op_class_e      op_class;
    logic           accept;

    logic           timer_clear;
    logic           timer_tick;
    logic           timer_expired;

    logic           capture_mem;
    logic           take_input_dest;
    logic           take_pend_dest;
    logic           wen_next;
    logic           err_next;
    logic [7:0]     wdata_next;

    logic           pend_store;
    logic [raw-1:0] pend_rt;
    logic           pend_func;
    logic [7:0]     mem_addr_q;
    logic [7:0]     mem_wdata_q;

    logic           wen_q;
    logic           err_q;
    logic [7:0]     wdata_q;
    logic [raw-1:0] rt_q;
    logic           func_q;

    wb_stage_wait_timer #(
        .LIMIT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .tick    (timer_tick),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An acknowledge on the expiry cycle still completes the access.
    always_comb begin
        state_next      = state;
        capture_mem     = 1'b0;
        take_input_dest = 1'b0;
        take_pend_dest  = 1'b0;
        wen_next        = 1'b0;
        err_next        = 1'b0;
        wdata_next      = wdata_q;
        timer_clear     = 1'b0;
        timer_tick      = 1'b0;
        accept          = (state == IDLE) && bus.in_valid_i;
        op_class        = classify_op(bus.is_load_i, bus.is_store_i);

        case (state)
            IDLE: begin
                if (accept) begin
                    case (op_class)
                        OP_ALU: begin
                            wen_next        = 1'b1;
                            wdata_next      = bus.alu_result_i;
                            take_input_dest = 1'b1;
                        end
                        OP_LOAD, OP_STORE: begin
                            state_next  = MEM_WAIT;
                            capture_mem = 1'b1;
                            timer_clear = 1'b1;
                        end
                        default: begin
                            err_next = 1'b1;
                        end
                    endcase
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ack_i) begin
                    state_next = IDLE;
                    if (!pend_store) begin
                        wen_next       = 1'b1;
                        wdata_next     = bus.mem_rdata_i;
                        take_pend_dest = 1'b1;
                    end
                end else if (timer_expired) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else begin
                    timer_tick = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_store  <= 1'b0;
            pend_rt     <= '0;
            pend_func   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wen_q       <= 1'b0;
            err_q       <= 1'b0;
            wdata_q     <= '0;
            rt_q        <= '0;
            func_q      <= 1'b0;
        end else begin
            wen_q   <= wen_next;
            err_q   <= err_next;
            wdata_q <= wdata_next;
            if (capture_mem) begin
                pend_store  <= bus.is_store_i;
                pend_rt     <= bus.rt_addr_i;
                pend_func   <= bus.func_i;
                mem_addr_q  <= bus.mem_addr_i;
                mem_wdata_q <= bus.store_data_i;
            end
            if (take_input_dest) begin
                rt_q   <= bus.rt_addr_i;
                func_q <= bus.func_i;
            end else if (take_pend_dest) begin
                rt_q   <= pend_rt;
                func_q <= pend_func;
            end
        end
    end

    assign bus.in_ready_o   = (state == IDLE);
    assign bus.mem_req_o    = (state == MEM_WAIT);
    assign bus.mem_we_o     = (state == MEM_WAIT) && pend_store;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_wdata_o  = mem_wdata_q;
    assign bus.wen_o        = wen_q;
    assign bus.write_data_o = wdata_q;
    assign bus.rt_addr_o    = rt_q;
    assign bus.func_o       = func_q;
    assign bus.err_o        = err_q;

endmodule
